// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan renderer: timing defaults, colours and object geometry.
package vga_pkg;

  localparam int unsigned DefClkDiv  = 2;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefHTotal  = DefHActive + DefHFp + DefHSync + DefHBp;
  localparam int unsigned DefVTotal  = DefVActive + DefVFp + DefVSync + DefVBp;

  localparam int unsigned PadHw = 25;
  localparam int unsigned PadHh = 33;
  localparam int unsigned BallW = 12;
  localparam int unsigned BallH = 17;

  localparam logic [11:0] ColP1Win = 12'hF00;
  localparam logic [11:0] ColP2Win = 12'h00F;
  localparam logic [11:0] ColBall  = 12'hFFF;
  localparam logic [11:0] ColP1    = 12'hF80;
  localparam logic [11:0] ColP2    = 12'h08F;
  localparam logic [11:0] ColLine  = 12'h444;
  localparam logic [11:0] ColBg    = 12'h000;

  localparam logic [2:0] WinP1 = 3'd1;
  localparam logic [2:0] WinP2 = 3'd2;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } pos_t;

  localparam pos_t RstP1   = '{x: 10'd80,  y: 9'd240};
  localparam pos_t RstP2   = '{x: 10'd560, y: 9'd240};
  localparam pos_t RstBall = '{x: 10'd320, y: 9'd240};

  // Inclusive span around a centre; the lower bound clamps at zero instead of wrapping.
  function automatic logic in_span(logic [10:0] v, logic [10:0] ctr, logic [10:0] half);
    logic [10:0] lo;
    lo = (ctr >= half) ? ctr - half : 11'd0;
    return (v >= lo) && (v <= ctr + half);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, horizontal/vertical scan counters and sync/active decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned ClkDiv  = DefClkDiv,
  parameter int unsigned HActive = DefHActive,
  parameter int unsigned HFp     = DefHFp,
  parameter int unsigned HSync   = DefHSync,
  parameter int unsigned HBp     = DefHBp,
  parameter int unsigned VActive = DefVActive,
  parameter int unsigned VFp     = DefVFp,
  parameter int unsigned VSync   = DefVSync,
  parameter int unsigned VBp     = DefVBp
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pix_en_o,
  output logic [9:0] hc_o,
  output logic [9:0] vc_o,
  output logic [9:0] vc_next_o,
  output logic       frame_end_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);
  localparam logic [9:0] HLast      = 10'(HActive + HFp + HSync + HBp - 1);
  localparam logic [9:0] VLast      = 10'(VActive + VFp + VSync + VBp - 1);
  localparam logic [9:0] HAct       = 10'(HActive);
  localparam logic [9:0] VAct       = 10'(VActive);
  localparam logic [9:0] HSyncStart = 10'(HActive + HFp);
  localparam logic [9:0] HSyncEnd   = 10'(HActive + HFp + HSync);
  localparam logic [9:0] VSyncStart = 10'(VActive + VFp);
  localparam logic [9:0] VSyncEnd   = 10'(VActive + VFp + VSync);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hc_q, hc_d, vc_q, vc_d;
  logic            pix_en, h_wrap;

  always_comb begin
    pix_en = (div_q == DivMax);
    div_d  = pix_en ? '0 : div_q + 1'b1;
    h_wrap = (hc_q == HLast);
    hc_d   = hc_q;
    vc_d   = vc_q;
    if (pix_en) begin
      hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = (vc_q == VLast) ? 10'd0 : vc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  always_comb begin
    pix_en_o    = pix_en;
    hc_o        = hc_q;
    vc_o        = vc_q;
    vc_next_o   = vc_d;
    frame_end_o = pix_en && h_wrap && (vc_q == VAct - 10'd1);
    hsync_o     = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    vsync_o     = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
    active_o    = (hc_q < HAct) && (vc_q < VAct);
  end

endmodule

// File: rtl/vga_scan_renderer.sv
// VGA scan-out for pong: per-frame object snapshots, colour priority and a pixel-aligned
// output register stage on top of vga_timing_gen.
module vga_scan_renderer
  import vga_pkg::*;
#(
  parameter int unsigned ClkDiv  = DefClkDiv,
  parameter int unsigned HActive = DefHActive,
  parameter int unsigned HFp     = DefHFp,
  parameter int unsigned HSync   = DefHSync,
  parameter int unsigned HBp     = DefHBp,
  parameter int unsigned VActive = DefVActive,
  parameter int unsigned VFp     = DefVFp,
  parameter int unsigned VSync   = DefVSync,
  parameter int unsigned VBp     = DefVBp
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  p1_xref_i,
  input  logic [8:0]  p1_yref_i,
  input  logic [9:0]  p2_xref_i,
  input  logic [8:0]  p2_yref_i,
  input  logic [9:0]  ball_x_i,
  input  logic [8:0]  ball_y_i,
  input  logic [2:0]  winner_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        active_o,
  output logic [9:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic [11:0] rgb_o,
  output logic        screen_end_o,
  output logic        frame_pulse_o
);

  localparam logic [9:0] VAct    = 10'(VActive);
  localparam logic [9:0] CenterX = 10'(HActive / 2 - 1);

  logic       pix_en, frame_end, hsync, vsync, active;
  logic [9:0] hc, vc, vc_next;

  vga_timing_gen #(
    .ClkDiv  (ClkDiv),
    .HActive (HActive),
    .HFp     (HFp),
    .HSync   (HSync),
    .HBp     (HBp),
    .VActive (VActive),
    .VFp     (VFp),
    .VSync   (VSync),
    .VBp     (VBp)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pix_en_o    (pix_en),
    .hc_o        (hc),
    .vc_o        (vc),
    .vc_next_o   (vc_next),
    .frame_end_o (frame_end),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .active_o    (active)
  );

  pos_t        p1_q, p2_q, ball_q;
  logic [2:0]  winner_q;
  logic        hsync_q, vsync_q, active_q, screen_end_q, frame_pulse_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] x, y;
  logic        hit_ball, hit_p1, hit_p2, hit_line;

  always_comb begin
    x        = {1'b0, hc};
    y        = {1'b0, vc};
    hit_ball = (x >= {1'b0, ball_q.x}) && (x < {1'b0, ball_q.x} + 11'(BallW)) &&
               (y >= {2'b0, ball_q.y}) && (y < {2'b0, ball_q.y} + 11'(BallH));
    hit_p1   = in_span(x, {1'b0, p1_q.x}, 11'(PadHw)) && in_span(y, {2'b0, p1_q.y}, 11'(PadHh));
    hit_p2   = in_span(x, {1'b0, p2_q.x}, 11'(PadHw)) && in_span(y, {2'b0, p2_q.y}, 11'(PadHh));
    hit_line = ((hc == CenterX) || (hc == CenterX + 10'd1)) && !vc[3];
    rgb_d    = ColBg;
    if (active) begin
      if (winner_q == WinP1)      rgb_d = ColP1Win;
      else if (winner_q == WinP2) rgb_d = ColP2Win;
      else if (hit_ball)          rgb_d = ColBall;
      else if (hit_p1)            rgb_d = ColP1;
      else if (hit_p2)            rgb_d = ColP2;
      else if (hit_line)          rgb_d = ColLine;
    end
  end

  // Snapshots only move at the start of vblank so a frame never mixes old and new positions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      rgb_q         <= '0;
      screen_end_q  <= 1'b0;
      frame_pulse_q <= 1'b0;
      p1_q          <= RstP1;
      p2_q          <= RstP2;
      ball_q        <= RstBall;
      winner_q      <= '0;
    end else begin
      if (pix_en) begin
        hsync_q      <= hsync;
        vsync_q      <= vsync;
        active_q     <= active;
        pix_x_q      <= hc;
        pix_y_q      <= vc[8:0];
        rgb_q        <= rgb_d;
        screen_end_q <= (vc_next >= VAct);
      end
      frame_pulse_q <= frame_end;
      if (frame_end) begin
        p1_q     <= '{x: p1_xref_i, y: p1_yref_i};
        p2_q     <= '{x: p2_xref_i, y: p2_yref_i};
        ball_q   <= '{x: ball_x_i, y: ball_y_i};
        winner_q <= winner_i;
      end
    end
  end

  always_comb begin
    hsync_o       = hsync_q;
    vsync_o       = vsync_q;
    active_o      = active_q;
    pix_x_o       = pix_x_q;
    pix_y_o       = pix_y_q;
    rgb_o         = rgb_q;
    screen_end_o  = screen_end_q;
    frame_pulse_o = frame_pulse_q;
  end

endmodule

// File: tb/tb_vga_scan_renderer.sv
// Directed bench: a full 640x480 instance for line timing and a reduced-geometry instance
// for frame timing, snapshots, colour priority and mid-frame reset.
module tb_vga_scan_renderer;

  // Reduced geometry: 112 x 55 total, 96 x 48 visible.
  localparam int unsigned SHTot = 112;
  localparam int unsigned SVTot = 55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f, rst_s;
  logic [9:0] fz10;
  logic [8:0] fz9;
  logic [2:0] fz3;
  logic [9:0] p1x, p2x, bx;
  logic [8:0] p1y, p2y, by;
  logic [2:0] win;

  logic f_hs, f_vs, f_act, f_se, f_fp;
  logic [9:0] f_px;
  logic [8:0] f_py;
  logic [11:0] f_rgb;
  logic s_hs, s_vs, s_act, s_se, s_fp;
  logic [9:0] s_px;
  logic [8:0] s_py;
  logic [11:0] s_rgb;

  int cyc_f, cyc_s;
  int n_cmp, n_bad;

  vga_scan_renderer u_full (
    .clk_i(clk), .rst_i(rst_f),
    .p1_xref_i(fz10), .p1_yref_i(fz9), .p2_xref_i(fz10), .p2_yref_i(fz9),
    .ball_x_i(fz10), .ball_y_i(fz9), .winner_i(fz3),
    .hsync_o(f_hs), .vsync_o(f_vs), .active_o(f_act), .pix_x_o(f_px), .pix_y_o(f_py),
    .rgb_o(f_rgb), .screen_end_o(f_se), .frame_pulse_o(f_fp)
  );

  vga_scan_renderer #(
    .ClkDiv(2), .HActive(96), .HFp(4), .HSync(8), .HBp(4),
    .VActive(48), .VFp(2), .VSync(2), .VBp(3)
  ) u_small (
    .clk_i(clk), .rst_i(rst_s),
    .p1_xref_i(p1x), .p1_yref_i(p1y), .p2_xref_i(p2x), .p2_yref_i(p2y),
    .ball_x_i(bx), .ball_y_i(by), .winner_i(win),
    .hsync_o(s_hs), .vsync_o(s_vs), .active_o(s_act), .pix_x_o(s_px), .pix_y_o(s_py),
    .rgb_o(s_rgb), .screen_end_o(s_se), .frame_pulse_o(s_fp)
  );

  always @(posedge clk) begin
    if (rst_f) cyc_f <= 0;
    else       cyc_f <= cyc_f + 1;
    if (rst_s) cyc_s <= 0;
    else       cyc_s <= cyc_s + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge index (counted from reset release) at which pixel (x,y) reaches the output registers.
  function automatic int ef(input int x, input int y);
    return 2 + 2 * (y * 800 + x);
  endfunction

  function automatic int es(input int f, input int x, input int y);
    return 2 + 2 * (f * SVTot * SHTot + y * SHTot + x);
  endfunction

  task automatic goto_f(input int n);
    if (cyc_f > n) begin
      n_cmp++; n_bad++;
      $error("FAIL goto_f: at edge %0d expected at most %0d", cyc_f, n);
    end
    while (cyc_f < n) begin @(posedge clk); #1; end
  endtask

  task automatic goto_s(input int n);
    if (cyc_s > n) begin
      n_cmp++; n_bad++;
      $error("FAIL goto_s: at edge %0d expected at most %0d", cyc_s, n);
    end
    while (cyc_s < n) begin @(posedge clk); #1; end
  endtask

  task automatic pix_s(input string tag, input int f, input int x, input int y,
                       input logic [11:0] exp);
    goto_s(es(f, x, y));
    check(tag, s_rgb, exp);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_f = 1'b1; rst_s = 1'b1;
    fz10 = '0; fz9 = '0; fz3 = '0;
    p1x = 10'd20; p1y = 9'd30; p2x = 10'd85; p2y = 9'd30;
    bx = 10'd40; by = 9'd10; win = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("f_rst_hsync", f_hs, 1'b1);
    check("f_rst_vsync", f_vs, 1'b1);
    check("f_rst_active", f_act, 1'b0);
    check("f_rst_rgb", f_rgb, 12'h000);
    check("f_rst_se", f_se, 1'b0);
    check("f_rst_fp", f_fp, 1'b0);

    // Full geometry: first pixel latency, centre line, active edge and hsync timing.
    @(negedge clk); rst_f = 1'b0;
    goto_f(1);         check("f_no_pix_yet", f_act, 1'b0);
    goto_f(2);         check("f_first_pix", f_act, 1'b1);
    goto_f(ef(318, 0)); check("f_318_0", f_rgb, 12'h000);
    goto_f(ef(319, 0)); check("f_319_0", f_rgb, 12'h444);
    goto_f(ef(320, 0)); check("f_320_0", f_rgb, 12'h444);
    check("f_pix_x", f_px, 10'd320);
    goto_f(ef(321, 0)); check("f_321_0", f_rgb, 12'h000);
    goto_f(ef(639, 0)); check("f_act_639", f_act, 1'b1);
    goto_f(ef(640, 0)); check("f_act_640", f_act, 1'b0);
    goto_f(1313); check("f_hs_before", f_hs, 1'b1);
    goto_f(1314); check("f_hs_fall", f_hs, 1'b0);
    goto_f(1505); check("f_hs_low_end", f_hs, 1'b0);
    goto_f(1506); check("f_hs_rise", f_hs, 1'b1);
    goto_f(2913); check("f_hs_period_pre", f_hs, 1'b1);
    goto_f(2914); check("f_hs_period", f_hs, 1'b0);
    goto_f(ef(320, 7)); check("f_line_y7", f_rgb, 12'h444);
    goto_f(ef(320, 8)); check("f_line_y8", f_rgb, 12'h000);
    check("f_pix_y", f_py, 9'd8);

    // Reduced geometry.
    check("s_rst_hsync", s_hs, 1'b1);
    check("s_rst_vsync", s_vs, 1'b1);
    check("s_rst_rgb", s_rgb, 12'h000);
    check("s_rst_se", s_se, 1'b0);
    @(negedge clk); rst_s = 1'b0;
    pix_s("s0_line", 0, 47, 0, 12'h444);
    pix_s("s0_no_snap", 0, 20, 30, 12'h000);
    goto_s(10751); check("s_fp_pre", s_fp, 1'b0); check("s_se_pre", s_se, 1'b0);
    goto_s(10752); check("s_fp_on", s_fp, 1'b1); check("s_se_rise", s_se, 1'b1);
    goto_s(10753); check("s_fp_off", s_fp, 1'b0); check("s_se_hold", s_se, 1'b1);
    goto_s(11201); check("s_vs_pre", s_vs, 1'b1);
    goto_s(11202); check("s_vs_fall", s_vs, 1'b0);
    goto_s(11649); check("s_vs_low", s_vs, 1'b0);
    goto_s(11650); check("s_vs_rise", s_vs, 1'b1);
    goto_s(12319); check("s_se_last", s_se, 1'b1);
    goto_s(12320); check("s_se_drop", s_se, 1'b0);

    pix_s("s1_59_0", 1, 59, 0, 12'h000);
    pix_s("s1_p2_lo", 1, 60, 0, 12'h08F);
    pix_s("s1_p1_clamp", 1, 0, 5, 12'hF80);
    pix_s("s1_ball_tl", 1, 40, 10, 12'hFFF);
    goto_s(es(1, 0, 20)); bx = 10'd70;
    pix_s("s1_ball_held", 1, 40, 25, 12'hFFF);
    pix_s("s1_p2_mid", 1, 70, 25, 12'h08F);
    pix_s("s1_ball_br", 1, 51, 26, 12'hFFF);
    pix_s("s1_ball_xout", 1, 52, 26, 12'h000);
    pix_s("s1_ball_yout", 1, 51, 27, 12'h000);
    pix_s("s1_line_on", 1, 47, 32, 12'h444);
    check("s1_pix_y", s_py, 9'd32);
    pix_s("s1_p1_hi", 1, 45, 40, 12'hF80);
    pix_s("s1_46_40", 1, 46, 40, 12'h000);
    pix_s("s1_line_gap", 1, 47, 40, 12'h000);
    pix_s("s1_blank", 1, 100, 40, 12'h000);
    check("s1_blank_act", s_act, 1'b0);
    goto_s(es(1, 111, 47)); check("s1_fp", s_fp, 1'b1);

    pix_s("s2_p1_old_ball", 2, 40, 25, 12'hF80);
    pix_s("s2_ball_new", 2, 70, 25, 12'hFFF);
    pix_s("s2_ball_right", 2, 81, 25, 12'hFFF);
    pix_s("s2_ball_past", 2, 82, 25, 12'h08F);
    goto_s(es(2, 0, 30)); win = 3'd2;
    pix_s("s2_win_held", 2, 0, 35, 12'hF80);

    pix_s("s3_win_00", 3, 0, 0, 12'h00F);
    pix_s("s3_win_blank", 3, 100, 0, 12'h000);
    pix_s("s3_win_95", 3, 95, 20, 12'h00F);

    // Mid-frame reset: outputs return to idle and the frame restarts from line 0.
    goto_s(es(3, 0, 30)); rst_s = 1'b1;
    @(posedge clk); #1;
    check("sr_hsync", s_hs, 1'b1);
    check("sr_vsync", s_vs, 1'b1);
    check("sr_rgb", s_rgb, 12'h000);
    check("sr_se", s_se, 1'b0);
    check("sr_act", s_act, 1'b0);
    @(negedge clk); rst_s = 1'b0;
    pix_s("sr_winner_clr", 0, 47, 0, 12'h444);
    goto_s(11201); check("sr_vs_pre", s_vs, 1'b1);
    goto_s(11202); check("sr_vs_fall", s_vs, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_renderer.md
Name: vga_scan_renderer

Overview:
- Upstream display stage for the pong system.
- Generates 640x480@60 VGA timing from the system clock.
- Produces the screen_end frame signal consumed by the regfile's posEdgeScreenEnd input.
- Renders paddles, ball and win screen from per-frame snapshots of the game-object coordinates that the regfile exposes.

Parameters:
- CLK_DIV, 2, system clocks per pixel (pixel-enable divider).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- PAD_HW, 25, paddle half-width.
- PAD_HH, 33, paddle half-height.
- BALL_W, 12, ball width; ball_x is the left edge.
- BALL_H, 17, ball height; ball_y is the top edge.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- p1_xRef  in  10  player-1 paddle centre x.
- p1_yRef  in  9  player-1 paddle centre y.
- p2_xRef  in  10  player-2 paddle centre x.
- p2_yRef  in  9  player-2 paddle centre y.
- ball_x  in  10  ball left edge.
- ball_y  in  9  ball top edge.
- winner  in  3  0 = game running; 1 = player 1 won; 2 = player 2 won; other values treated as 0.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- active  out  1  high while the current pixel is visible.
- pix_x  out  10  current pixel column.
- pix_y  out  9  current pixel row; valid when active=1.
- rgb  out  12  4:4:4 pixel colour, forced to 0 when active=0.
- screen_end  out  1  high throughout vertical blanking.
- frame_pulse  out  1  one system-clock pulse at the start of vblank.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state updates on the posedge of clock.
- Divider: counter runs 0..CLK_DIV-1; pix_en is high when the count equals CLK_DIV-1.
- Horizontal counter hc (10 bits): 0..799. Advances only on pix_en and wraps 799->0.
- Vertical counter vc (10 bits): advances when hc wraps, range 0..524, wraps 524->0.
- Timing decode, from counter values:
  - hsync = 0 for hc in [656,751].
  - vsync = 0 for vc in [490,491].
  - active = (hc<640 && vc<480).
  - All boundaries are derived from the parameters.
- Output register stage: hsync, vsync, active, pix_x, pix_y and rgb are registered together and update only on pix_en. Latency is exactly one pixel (CLK_DIV clocks) from counter state to pins. All these outputs stay mutually aligned.
- screen_end: registered level, equal to (vc>=480). It updates on the same cycle as the other outputs.
- frame_pulse: high for exactly one clock on the pix_en where vc goes 479->480 (hc wrap).
- Snapshot: on that same cycle, latch p1/p2/ball/winner into internal registers. Rendering uses only the snapshots, so there is no tearing mid-frame. Input changes during the active region have no visible effect until the next vblank.
- Colour priority, applied to the registered pixel:
  1. winner snapshot 1 -> full-screen 0xF00.
  2. winner snapshot 2 -> full-screen 0x00F.
  3. Otherwise ball box -> 0xFFF.
  4. Otherwise p1 box -> 0xF80.
  5. Otherwise p2 box -> 0x08F.
  6. Otherwise centre line (pix_x in [319,320], pix_y bit3=0) -> 0x444.
  7. Otherwise 0x000.
- Box rules:
  - Paddle box is inclusive on both edges, compared in 11-bit unsigned arithmetic: xRef-PAD_HW <= x <= xRef+PAD_HW, likewise for y with PAD_HH. An underflowing lower bound clamps to 0.
  - Ball box: ball_x <= x < ball_x+BALL_W, ball_y <= y < ball_y+BALL_H.
- Reset values (also on reset mid-frame):
  - Counters 0.
  - hsync=1, vsync=1, active=0, pix_x=0, pix_y=0, rgb=0.
  - screen_end=0, frame_pulse=0.
  - Snapshots: p1=(80,240), p2=(560,240), ball=(320,240), winner=0.
  - The first pix_en after reset release is at clock CLK_DIV-1.
- Simultaneous events: hc and vc wrap together at (799,524) -> (0,0); screen_end drops on that pixel.

Decomposition:
- Shared package vga_pkg:
  - timing constants and derived totals (H_TOTAL=800, V_TOTAL=525);
  - colour constants;
  - paddle/ball geometry defaults and reset positions.
- One natural sub-module, vga_timing_gen: divider, hc/vc counters and sync/active decode.
- vga_scan_renderer instantiates vga_timing_gen and adds the snapshot, box compare and output register stage.

Test Plan:
- Reset then run 2 frames at CLK_DIV=2 -> hsync period exactly 1600 clocks with low width 192. vsync period 840000 clocks with low width 2 lines (3200 clocks).
- Count frame_pulse over 3 frames -> exactly 3 pulses, each 1 clock wide, coincident with the screen_end rising edge. screen_end high for 45 lines per frame.
- Default snapshots, sample pixel (80,240) -> rgb=0xF80; (55,207) -> 0xF80; (54,207) -> 0x000; (560,273) -> 0x08F; (325,245) -> 0xFFF; (320,0) -> 0x444.
- Change ball_x to 100 mid-frame at line 200 -> current frame still shows the ball at 320; after the next frame_pulse the ball appears at pixel (100,240).
- winner=2 latched at vblank -> every active pixel of the next frame is 0x00F; blanking pixels are 0x000.
- Assert reset for 1 clock at line 300 -> next clock hsync=1, vsync=1, rgb=0, screen_end=0; the counters restart so the next vsync low begins 490 lines later.
